// File: rtl/stage_controller.sv
// Bomb-stage sequencer: countdown, defuse-code check and strike counting.
// Optional feature macro: STAGE_STRIKES_EN (multi-strike counter; otherwise one wrong code is fatal).
module stage_controller #(
    parameter int         TICK_CYCLES = 50_000_000,
    parameter int         COUNTDOWN_S = 30,
    parameter logic [7:0] CODE        = 8'hA5,
    parameter int         MAX_STRIKES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic [7:0] code_in,
    input  logic       clear,
    output logic [1:0] state,
    output logic [5:0] seconds_left,
    output logic [2:0] strikes,
    output logic       defused,
    output logic       exploded
);

    typedef enum logic [1:0] {
        WAITING   = 2'd0,
        COUNTDOWN = 2'd1,
        SUCCESS   = 2'd2,
        FAILURE   = 2'd3
    } state_t;

    localparam int         TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [5:0] SECS_INIT = 6'(COUNTDOWN_S);

    state_t          cur;
    logic [TW-1:0]   tick;
    logic            tick_wrap;
    logic            code_ok;
    logic [2:0]      strikes_next;
    logic            strike_out;

    assign tick_wrap = (tick == TW'(TICK_CYCLES - 1));
    assign code_ok   = (code_in == CODE);
    assign state     = cur;

`ifdef STAGE_STRIKES_EN
    localparam logic [2:0] STRIKE_LIMIT = 3'(MAX_STRIKES);
    assign strikes_next = strikes + 3'd1;
    assign strike_out   = (strikes_next == STRIKE_LIMIT);
`else
    // Counter stays at zero; MAX_STRIKES is always >= 1, so the limit is one wrong code.
    localparam logic [2:0] STRIKE_LIMIT = 3'(MAX_STRIKES > 0);
    assign strikes_next = 3'd0;
    assign strike_out   = (3'd1 >= STRIKE_LIMIT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur          <= WAITING;
            seconds_left <= SECS_INIT;
            strikes      <= 3'd0;
            tick         <= '0;
            defused      <= 1'b0;
            exploded     <= 1'b0;
        end else begin
            defused  <= 1'b0;
            exploded <= 1'b0;
            case (cur)
                WAITING: begin
                    if (start) begin
                        cur          <= COUNTDOWN;
                        seconds_left <= SECS_INIT;
                        strikes      <= 3'd0;
                        tick         <= '0;
                    end
                end
                COUNTDOWN: begin
                    tick <= tick_wrap ? '0 : tick + 1'b1;
                    // A correct code wins outright and freezes the clock.
                    if (submit && code_ok) begin
                        cur     <= SUCCESS;
                        defused <= 1'b1;
                    end else begin
                        if (submit) begin
                            strikes <= strikes_next;
                        end
                        if (tick_wrap) begin
                            seconds_left <= (seconds_left > 6'd1) ? seconds_left - 6'd1 : 6'd0;
                        end
                        if ((submit && strike_out) || (tick_wrap && seconds_left <= 6'd1)) begin
                            cur      <= FAILURE;
                            exploded <= 1'b1;
                        end
                    end
                end
                SUCCESS, FAILURE: begin
                    if (clear) begin
                        cur          <= WAITING;
                        seconds_left <= SECS_INIT;
                        strikes      <= 3'd0;
                        tick         <= '0;
                    end
                end
                default: cur <= WAITING;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_controller.sv
// Table-driven scoreboard bench for stage_controller (TICK_CYCLES=4, COUNTDOWN_S=3, CODE=5A, MAX_STRIKES=2).
module tb_stage_controller;

`ifdef STAGE_STRIKES_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       clear = 1'b0;
    logic [1:0] state;
    logic [5:0] seconds_left;
    logic [2:0] strikes;
    logic       defused;
    logic       exploded;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       start;
        logic       submit;
        logic [7:0] code;
        logic       clear;
        logic [1:0] st;
        logic [5:0] secs;
        logic       chk_secs;
        logic [2:0] strk;
        logic       def;
        logic       expl;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    stage_controller #(
        .TICK_CYCLES(4),
        .COUNTDOWN_S(3),
        .CODE(8'h5A),
        .MAX_STRIKES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .submit(submit),
        .code_in(code_in),
        .clear(clear),
        .state(state),
        .seconds_left(seconds_left),
        .strikes(strikes),
        .defused(defused),
        .exploded(exploded)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic addVec(input logic s, input logic sub, input logic [7:0] c, input logic clr,
                          input logic [1:0] st, input int secs, input logic chk,
                          input int strk, input logic def, input logic expl);
        vec_t v;
        v.start = s; v.submit = sub; v.code = c; v.clear = clr;
        v.st = st; v.secs = 6'(secs); v.chk_secs = chk; v.strk = 3'(strk);
        v.def = def; v.expl = expl;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int idx, input vec_t e);
        logic ok;
        ok = (state === e.st) && (strikes === e.strk) && (defused === e.def) &&
             (exploded === e.expl) && (!e.chk_secs || seconds_left === e.secs);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL %s[%0d]: got st=%0d secs=%0d strk=%0d def=%0b expl=%0b, want st=%0d secs=%0d(chk=%0b) strk=%0d def=%0b expl=%0b",
                     name, idx, state, seconds_left, strikes, defused, exploded,
                     e.st, e.secs, e.chk_secs, e.strk, e.def, e.expl);
        end
    endtask

    task automatic applyStimulus(input string name, input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        start = v.start; submit = v.submit; code_in = v.code; clear = v.clear;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checkOutput(name, idx, e);
    endtask

    initial begin
        vec_t rv;
        int   s1;

        // Timeout run: seconds 3,2,1 then FAILURE at +12
        addVec(1, 0, 8'h00, 0, 2'd1, 3, 1, 0, 0, 0);
        for (int i = 1; i <= 11; i++) addVec(0, 0, 8'h00, 0, 2'd1, 3 - i / 4, 1, 0, 0, 0);
        addVec(0, 0, 8'h00, 0, 2'd3, 0, 1, 0, 0, 1);
        addVec(0, 0, 8'h00, 0, 2'd3, 0, 1, 0, 0, 0);
        addVec(1, 1, 8'h5A, 0, 2'd3, 0, 1, 0, 0, 0);
        addVec(0, 0, 8'h00, 1, 2'd0, 3, 1, 0, 0, 0);
        addVec(0, 1, 8'h5A, 0, 2'd0, 3, 1, 0, 0, 0);
        addVec(0, 0, 8'h00, 1, 2'd0, 3, 1, 0, 0, 0);

        // Correct code at +5, then frozen for 20 cycles despite stray inputs
        addVec(1, 0, 8'h00, 0, 2'd1, 3, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) addVec(0, 0, 8'h00, 0, 2'd1, 3 - i / 4, 1, 0, 0, 0);
        addVec(0, 1, 8'h5A, 0, 2'd2, 2, 1, 0, 1, 0);
        for (int i = 0; i < 20; i++)
            addVec(i == 3, (i == 7) || (i == 11), (i == 11) ? 8'h00 : 8'h5A, 0, 2'd2, 2, 1, 0, 0, 0);
        addVec(0, 0, 8'h00, 1, 2'd0, 3, 1, 0, 0, 0);

        // Wrong codes: strike count, strike-out and clear
        addVec(1, 0, 8'h00, 0, 2'd1, 3, 1, 0, 0, 0);
        if (EN) begin
            addVec(0, 1, 8'h00, 0, 2'd1, 3, 1, 1, 0, 0);
            addVec(0, 1, 8'h00, 0, 2'd3, 3, 1, 2, 0, 1);
            addVec(0, 0, 8'h00, 0, 2'd3, 3, 1, 2, 0, 0);
        end else begin
            addVec(0, 1, 8'h00, 0, 2'd3, 3, 1, 0, 0, 1);
            addVec(0, 1, 8'h00, 0, 2'd3, 3, 1, 0, 0, 0);
            addVec(0, 0, 8'h00, 0, 2'd3, 3, 1, 0, 0, 0);
        end
        addVec(0, 0, 8'h00, 1, 2'd0, 3, 1, 0, 0, 0);

        // Correct code on the final wrap; start/clear mid-countdown ignored
        addVec(1, 0, 8'h00, 0, 2'd1, 3, 1, 0, 0, 0);
        for (int i = 1; i <= 11; i++)
            addVec(i == 5, 0, 8'h00, i == 6, 2'd1, 3 - i / 4, 1, 0, 0, 0);
        addVec(0, 1, 8'h5A, 0, 2'd2, 1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) addVec(0, 0, 8'h00, 0, 2'd2, 1, 1, 0, 0, 0);
        addVec(0, 0, 8'h00, 1, 2'd0, 3, 1, 0, 0, 0);

        // Wrong code on the final wrap: FAILURE, strike still counted
        addVec(1, 0, 8'h00, 0, 2'd1, 3, 1, 0, 0, 0);
        for (int i = 1; i <= 11; i++) addVec(0, 0, 8'h00, 0, 2'd1, 3 - i / 4, 1, 0, 0, 0);
        s1 = EN ? 1 : 0;
        addVec(0, 1, 8'h33, 0, 2'd3, 0, 0, s1, 0, 1);
        addVec(0, 0, 8'h00, 0, 2'd3, 0, 0, s1, 0, 0);
        addVec(0, 0, 8'h00, 1, 2'd0, 3, 1, 0, 0, 0);

        // Reset values, checked after a clock edge with rst held high
        @(posedge clk);
        #1;
        rv.start = 0; rv.submit = 0; rv.code = 0; rv.clear = 0;
        rv.st = 2'd0; rv.secs = 6'd3; rv.chk_secs = 1; rv.strk = 3'd0; rv.def = 0; rv.expl = 0;
        checkOutput("reset", 0, rv);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) applyStimulus("vec", i, vecs[i]);

        // Asynchronous reset mid-countdown, observed between clock edges
        applyStimulus("arst", 0, '{1, 0, 8'h00, 0, 2'd1, 6'd3, 1, 3'd0, 0, 0});
        applyStimulus("arst", 1, '{0, 0, 8'h00, 0, 2'd1, 6'd3, 1, 3'd0, 0, 0});
        applyStimulus("arst", 2, '{0, 0, 8'h00, 0, 2'd1, 6'd3, 1, 3'd0, 0, 0});
        @(negedge clk);
        start = 0; submit = 0; clear = 0;
        #2 rst = 1'b1;
        #1 checkOutput("arst_now", 3, rv);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("arst", 4, '{0, 1, 8'h5A, 0, 2'd0, 6'd3, 1, 3'd0, 0, 0});
        applyStimulus("arst", 5, '{1, 0, 8'h00, 0, 2'd1, 6'd3, 1, 3'd0, 0, 0});
        for (int i = 1; i <= 4; i++)
            applyStimulus("arst", 5 + i, '{0, 0, 8'h00, 0, 2'd1, 6'(3 - i / 4), 1, 3'd0, 0, 0});

        @(negedge clk);
        start = 0; submit = 0; clear = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
